// File: rtl/pulse_gen_pkg.sv
// Shared types for the multi-channel pulse generator: per-channel FSM states
// and retrigger policy codes.
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HIGH    = 2'd1,
    ST_HOLDOFF = 2'd2
  } ch_state_e;

  localparam int RETRIG_IGNORE  = 0;
  localparam int RETRIG_RESTART = 1;

endpackage

// File: rtl/pulse_gen_channel.sv
// One pulse channel: trigger synchroniser, rising-edge detect, width counter FSM
// and sticky missed flag. Optional post-pulse holdoff via PULSE_GEN_HOLDOFF_EN.
module pulse_gen_channel
  import pulse_gen_pkg::*;
#(
  parameter int CNT_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int RETRIG         = RETRIG_IGNORE,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             missed_clr_i,
  output logic             pulse_o,
  output logic             missed_o,
  output logic [1:0]       state_o
);

`ifdef PULSE_GEN_HOLDOFF_EN
  localparam bit HOLDOFF_ON = (HOLDOFF_CYCLES > 0);
`else
  localparam bit HOLDOFF_ON = 1'b0;
`endif

  localparam logic [CNT_W-1:0] HOLDOFF_LOAD =
    (HOLDOFF_CYCLES >= (2 ** CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(HOLDOFF_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  ch_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   pulse_q, pulse_d;
  logic                   missed_q, missed_d;

  logic                   sync_out;
  logic                   rise;
  logic                   drop;
  logic [CNT_W-1:0]       width_eff;

  assign sync_out  = sync_q[SYNC_STAGES-1];
  assign rise      = sync_out & ~prev_q;
  assign width_eff = (width_i == '0) ? CNT_W'(1) : width_i;

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], trigger_i};
    prev_d   = sync_out;
    state_d  = state_q;
    cnt_d    = cnt_q;
    pulse_d  = pulse_q;
    drop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          cnt_d   = width_eff;
          pulse_d = 1'b1;
        end
      end
      ST_HIGH: begin
        // A restart reload takes priority over the final-cycle fall, so no low glitch.
        if (rise && (RETRIG == RETRIG_RESTART)) begin
          cnt_d = width_eff;
        end else begin
          drop = rise;
          if (cnt_q <= CNT_W'(1)) begin
            pulse_d = 1'b0;
            if (HOLDOFF_ON) begin
              state_d = ST_HOLDOFF;
              cnt_d   = HOLDOFF_LOAD;
            end else begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_HOLDOFF: begin
        drop = rise;
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        pulse_d = 1'b0;
      end
    endcase
    // Set wins over a coincident clear.
    missed_d = (missed_q & ~missed_clr_i) | drop;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      prev_q   <= 1'b1;
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
      missed_q <= missed_d;
    end
  end

  assign pulse_o  = pulse_q;
  assign missed_o = missed_q;
  assign state_o  = state_q;

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel clocked pulse generator; CHANNELS independent pulse_gen_channel
// instances. Post-pulse holdoff is compiled in with PULSE_GEN_HOLDOFF_EN.
module pulse_gen_multi
  import pulse_gen_pkg::*;
#(
  parameter int CHANNELS       = 4,
  parameter int CNT_W          = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int RETRIG         = RETRIG_IGNORE,
  parameter int HOLDOFF_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       trigger,
  input  logic [CHANNELS*CNT_W-1:0] width_cycles,
  input  logic [CHANNELS-1:0]       missed_clr,
  output logic [CHANNELS-1:0]       pulse,
  output logic [CHANNELS-1:0]       busy,
  output logic [CHANNELS-1:0]       missed
);

  logic [2*CHANNELS-1:0] ch_state;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    pulse_gen_channel #(
      .CNT_W          (CNT_W),
      .SYNC_STAGES    (SYNC_STAGES),
      .RETRIG         (RETRIG),
      .HOLDOFF_CYCLES (HOLDOFF_CYCLES)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .trigger_i    (trigger[g]),
      .width_i      (width_cycles[g*CNT_W +: CNT_W]),
      .missed_clr_i (missed_clr[g]),
      .pulse_o      (pulse[g]),
      .missed_o     (missed[g]),
      .state_o      (ch_state[g*2 +: 2])
    );

    // busy is simply "state register not IDLE", so it covers HIGH and HOLDOFF.
    assign busy[g] = (ch_state[g*2 +: 2] != ST_IDLE);
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed bench for pulse_gen_multi: two instances (ignore / restart retrigger)
// driven by the same stimulus, checked with immediate assertions.
module tb_pulse_gen_multi;
  localparam int CH = 2;
  localparam int CW = 8;

`ifdef PULSE_GEN_HOLDOFF_EN
  localparam logic BUSY_AFTER_FALL = 1'b1;
`else
  localparam logic BUSY_AFTER_FALL = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [CH-1:0]    trigger = '0;
  logic [CH-1:0]    missed_clr = '0;
  logic [CH*CW-1:0] width_cycles = '0;
  logic [CH-1:0]    pulse_a, busy_a, missed_a;
  logic [CH-1:0]    pulse_b, busy_b, missed_b;

  int n_tests = 0;
  int n_fail  = 0;

  // clock / reset
  always #10 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

  pulse_gen_multi #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2), .RETRIG(0), .HOLDOFF_CYCLES(4)) dut_a (
    .clk(clk), .rst(rst), .trigger(trigger), .width_cycles(width_cycles),
    .missed_clr(missed_clr), .pulse(pulse_a), .busy(busy_a), .missed(missed_a));

  pulse_gen_multi #(.CHANNELS(CH), .CNT_W(CW), .SYNC_STAGES(2), .RETRIG(1), .HOLDOFF_CYCLES(4)) dut_b (
    .clk(clk), .rst(rst), .trigger(trigger), .width_cycles(width_cycles),
    .missed_clr(missed_clr), .pulse(pulse_b), .busy(busy_b), .missed(missed_b));

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles from trigger to pulse, pulse width, and high samples on the other channel.
  task automatic measure(input int ch, output int lat, output int wid, output int other);
    lat = 0; wid = 0; other = 0;
    while (!pulse_a[ch] && lat < 20) begin
      tick(); lat++; other += int'(pulse_a[1-ch]);
    end
    while (pulse_a[ch] && wid < 300) begin
      wid++; tick(); other += int'(pulse_a[1-ch]);
    end
  endtask

  // Trigger ch0 at cycle 1, then again at cycle 6 so the second rise lands 5 cycles into the pulse.
  task automatic retrig_run(input logic clr, output int hi_a, output int hi_b,
                            output int rises_b, output logic m8, output logic m9);
    logic last_b;
    last_b = 1'b0; hi_a = 0; hi_b = 0; rises_b = 0; m8 = 1'bx; m9 = 1'bx;
    for (int i = 1; i <= 30; i++) begin
      trigger[0]    = (i == 1) || (i >= 6 && i <= 12);
      missed_clr[0] = clr;
      tick();
      hi_a += int'(pulse_a[0]);
      hi_b += int'(pulse_b[0]);
      if (pulse_b[0] && !last_b) rises_b++;
      last_b = pulse_b[0];
      if (i == 8) m8 = missed_a[0];
      if (i == 9) m9 = missed_a[0];
    end
    trigger[0]    = 1'b0;
    missed_clr[0] = 1'b0;
  endtask

  initial begin
    int lat, wid, other, hi_a, hi_b, rises_b, hi0, hi1;
    logic m8, m9;

    // reset state
    idle(3);
    chk("rst_pulse_a", pulse_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_missed_a", missed_a, 0);
    chk("rst_pulse_b", pulse_b, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_missed_b", missed_b, 0);
    rst = 1'b0;
    idle(3);

    // basic: width 25 on ch0, ch1 untouched
    width_cycles = {8'd7, 8'd25};
    trigger[0] = 1'b1;
    measure(0, lat, wid, other);
    chk("basic_latency", lat, 3);
    chk("basic_width", wid, 25);
    chk("basic_ch1_quiet", other, 0);
    trigger[0] = 1'b0;
    idle(8);

    // zero width behaves as one cycle
    width_cycles[7:0] = 8'd0;
    trigger[0] = 1'b1;
    idle(3);
    chk("zero_pulse_hi", pulse_a[0], 1);
    chk("zero_busy_hi", busy_a[0], 1);
    tick();
    chk("zero_pulse_lo", pulse_a[0], 0);
    chk("zero_busy_after", busy_a[0], BUSY_AFTER_FALL);
    trigger[0] = 1'b0;
    idle(8);

    // retrigger 5 cycles into a 10-cycle pulse
    width_cycles[7:0] = 8'd10;
    retrig_run(1'b0, hi_a, hi_b, rises_b, m8, m9);
    chk("ignore_width", hi_a, 10);
    chk("restart_width", hi_b, 15);
    chk("restart_no_glitch", rises_b, 1);
    chk("ignore_missed", missed_a[0], 1);
    chk("restart_missed", missed_b[0], 0);
    chk("ch1_missed_quiet", missed_a[1], 0);
    missed_clr[0] = 1'b1;
    tick();
    missed_clr[0] = 1'b0;
    chk("missed_clr", missed_a[0], 0);
    idle(8);

    // clear held high across the dropped rise: set wins, then clear takes effect
    retrig_run(1'b1, hi_a, hi_b, rises_b, m8, m9);
    chk("set_wins_clr", m8, 1);
    chk("clr_after_set", m9, 0);
    idle(8);

    // simultaneous rises on both channels with different widths
    width_cycles = {8'd6, 8'd4};
    trigger = 2'b11;
    hi0 = 0; hi1 = 0;
    for (int i = 0; i < 14; i++) begin
      tick();
      hi0 += int'(pulse_a[0]);
      hi1 += int'(pulse_a[1]);
    end
    chk("simul_ch0_width", hi0, 4);
    chk("simul_ch1_width", hi1, 6);

    // trigger held high through reset yields no pulse
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    hi0 = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      hi0 += int'(pulse_a[0]) + int'(pulse_a[1]) + int'(pulse_b[0]) + int'(pulse_b[1]);
    end
    chk("held_through_rst", hi0, 0);
    trigger = 2'b00;
    idle(8);

    // reset 3 cycles into a pulse
    width_cycles[7:0] = 8'd20;
    trigger[0] = 1'b1;
    idle(3);
    chk("midrst_pulse_hi", pulse_a[0], 1);
    idle(3);
    rst = 1'b1;
    tick();
    chk("midrst_pulse_lo", pulse_a[0], 0);
    chk("midrst_busy_lo", busy_a[0], 0);
    rst = 1'b0;
    hi0 = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      hi0 += int'(pulse_a[0]);
    end
    chk("midrst_no_restart", hi0, 0);
    trigger[0] = 1'b0;
    idle(8);

`ifdef PULSE_GEN_HOLDOFF_EN
    // holdoff: width 3, rise 2 cycles after the fall dropped, 5 cycles after accepted
    width_cycles[7:0] = 8'd3;
    hi_a = 0; rises_b = 0; m8 = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      trigger[0] = (i == 1) || (i == 6) || (i >= 9 && i <= 12);
      tick();
      hi_a += int'(pulse_a[0]);
      if (pulse_a[0] && !m8) rises_b++;
      m8 = pulse_a[0];
      if (i == 9)  chk("holdoff_busy_held", busy_a[0], 1);
      if (i == 10) chk("holdoff_busy_fall", busy_a[0], 0);
    end
    trigger[0] = 1'b0;
    chk("holdoff_high_cycles", hi_a, 6);
    chk("holdoff_pulses", rises_b, 2);
    chk("holdoff_missed", missed_a[0], 1);
    idle(8);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pulse_gen_multi.md
# pulse_gen_multi

Clocked, multi-channel successor to the fixed-width delay-based pulse generators. Each channel synchronises an asynchronous trigger, detects its rising edge and drives a clean output pulse whose width is a run-time cycle count, with a selectable retrigger policy and a sticky missed-trigger flag. It sits between console-side strobe/latch inputs and the replay logic, replacing the 100 ns / 500 ns / 1 µs variants with one synthesizable block.

## Interface
Parameters:
- CHANNELS, 4, number of independent channels (1..16)
- CNT_W, 8, width of the per-channel pulse-width count
- SYNC_STAGES, 2, trigger synchroniser depth (2..4)
- RETRIG, 0, retrigger policy: 0 = ignore (flag missed), 1 = restart count
- HOLDOFF_CYCLES, 4, minimum low gap after a pulse; used only when holdoff is compiled in

Ports:
- clk  in  1  system clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- trigger  in  CHANNELS  asynchronous trigger inputs, one bit per channel
- width_cycles  in  CHANNELS*CNT_W  pulse width in clk cycles, channel n at bits [n*CNT_W +: CNT_W]
- missed_clr  in  CHANNELS  clears the matching missed bit
- pulse  out  CHANNELS  registered output pulses
- busy  out  CHANNELS  high while the channel is not IDLE
- missed  out  CHANNELS  sticky: a rising edge was dropped

## Operation
- Per channel: SYNC_STAGES-flop synchroniser, a prev register, and rise = sync_out & ~prev.
- States: IDLE, HIGH, and HOLDOFF when compiled in.
- IDLE + rise -> HIGH.
  - Latch W = width_cycles; W = 0 is treated as 1.
  - Load the down-counter with W.
  - pulse = 1.
- HIGH: decrement each cycle. When the count reaches 1 with no restart, go to HOLDOFF (or IDLE) and set pulse = 0.
- A rise while in HIGH, including the final cycle:
  - RETRIG=0: ignored; missed set; the pulse keeps its original width.
  - RETRIG=1: counter reloaded from the current width_cycles; pulse stays high with no low glitch. Total width = elapsed cycles + new W.
- width_cycles changes mid-pulse have no effect except on an RETRIG=1 reload.
- missed: set on a dropped rise; cleared by missed_clr. If set and clear coincide, set wins.
- Channels are fully independent; simultaneous rises on all channels are each handled.
- Counter width is CNT_W; the maximum pulse is 2^CNT_W − 1 cycles; no wrap is possible.

## Timing
- Reset values:
  - pulse = 0, busy = 0, missed = 0, state = IDLE, counters = 0.
  - Synchroniser and prev registers reset to all-1s, so a trigger held high through reset produces no pulse. A rise requires an observed low.
- Latency: trigger sampled high at edge k -> pulse high after edge k+SYNC_STAGES. It stays high for exactly W cycles.
- busy rises with pulse. It falls with pulse without holdoff, or HOLDOFF_CYCLES cycles later with holdoff.
- Reset mid-pulse: pulse drops on the next edge and the in-flight pulse is discarded.
- Minimum trigger high/low time for detection: 1 clk period plus synchroniser margin. Narrower glitches may be missed.

## Configuration
- Macro: PULSE_GEN_HOLDOFF_EN.
- Defined: after HIGH the channel enters HOLDOFF for HOLDOFF_CYCLES cycles with pulse = 0 and busy = 1. Rises during HOLDOFF are dropped and set missed. HOLDOFF_CYCLES = 0 behaves as if the macro is undefined.
- Undefined: HIGH -> IDLE directly. A rise on the first IDLE cycle starts a new pulse, so the minimum low gap is 1 cycle. HOLDOFF_CYCLES is unused.

## Structure
- Package pulse_gen_pkg holds:
  - the channel state enum (IDLE, HIGH, HOLDOFF)
  - RETRIG_IGNORE / RETRIG_RESTART constants
- One sub-module, pulse_gen_channel, contains the synchroniser, edge detect, FSM, counter and missed flag for a single channel.
- pulse_gen_multi instantiates CHANNELS copies in a generate loop and slices width_cycles.

## Test plan
Common setup: CHANNELS=2, CNT_W=8, SYNC_STAGES=2, 20 ns clk.
- Basic: width=25, trigger ch0 high at edge 10 -> pulse[0] high after edge 12 for exactly 25 cycles (500 ns); ch1 unaffected.
- Zero width: width=0, trigger -> 1-cycle pulse; busy high 1 cycle (holdoff off).
- Retrigger, RETRIG=0: width=10, second rise 5 cycles into the pulse -> pulse high 10 cycles total, missed[0]=1; then missed_clr -> missed[0]=0 next edge.
- Retrigger, RETRIG=1: same stimulus -> pulse high continuously 5+10=15 cycles, missed stays 0.
- Reset behaviour: trigger held high through rst, release -> no pulse. Assert rst 3 cycles into a pulse -> pulse=0 after that edge and busy=0.
- Holdoff (macro defined, HOLDOFF_CYCLES=4): width=3, rise 2 cycles after the fall -> dropped, missed=1. Rise 5 cycles after the fall -> new 3-cycle pulse.
